trunc_mult_arbiter: RTL and testbench
=====================================

// Module: trunc_mult_arbiter
// PURPOSE
//  Shares one combinational truncated array multiplier (BIT_WIDTH x BIT_WIDTH -> RESULT_BIT_WIDTH MSBs)
//  among NUM_REQ requesters. Round-robin arbitration, valid/ready handshakes on both sides.
//  Registered operands drive the multiplier; the result is captured after MUL_LATENCY cycles
//  and returned with the requester ID. Sits between client logic and the array_t multiplier.
// PARAMETERS
//  BIT_WIDTH        6  operand width
//  RESULT_BIT_WIDTH 8  truncated result width (MSBs of the 2*BIT_WIDTH product)
//  NUM_REQ          4  requester count, 2..8
//  MUL_LATENCY      1  settle cycles allowed for the multiplier after operands are registered, >=1
//  ID_W             2  clog2(NUM_REQ), width of rsp_id
// PORTS
//  clk         in   1                    clock, rising edge
//  reset       in   1                    asynchronous, active-low
//  req_valid   in   NUM_REQ              per-requester request valid
//  req_ready   out  NUM_REQ              per-requester grant/accept (one-hot or zero)
//  req_x       in   NUM_REQ*BIT_WIDTH    operand x, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//  req_y       in   NUM_REQ*BIT_WIDTH    operand y, same packing
//  mul_x       out  BIT_WIDTH            registered operand x to the multiplier
//  mul_y       out  BIT_WIDTH            registered operand y to the multiplier
//  mul_result  in   RESULT_BIT_WIDTH     truncated product from the multiplier
//  rsp_valid   out  1                    response valid
//  rsp_ready   in   1                    response consumer ready
//  rsp_id      out  ID_W                 requester index of the response
//  rsp_result  out  RESULT_BIT_WIDTH     captured truncated product
//  busy        out  1                    high in any state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, mul_x/mul_y=0, rsp_valid=0, rsp_id=0, rsp_result=0, req_ready=0.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready is combinational, one-hot on the first valid requester at or after rr_ptr
//    (wrapping at NUM_REQ-1 -> 0). It is all-zero if no valid requester or state != IDLE.
//  - On a handshake (req_valid[g] & req_ready[g]): mul_x/mul_y <= req_x/req_y[g], rsp_id <= g,
//    cnt <= MUL_LATENCY, go to WAIT.
//  - WAIT: cnt decrements each cycle. When cnt==1: rsp_result <= mul_result, rsp_valid <= 1, go to RESP.
//  - RESP: rsp_valid, rsp_id and rsp_result stay stable until rsp_ready=1.
//    On rsp_valid & rsp_ready: rsp_valid <= 0, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1, go to IDLE.
//  - Latency: the handshake is cycle 0; rsp_valid rises at the edge ending cycle MUL_LATENCY.
//    Minimum issue interval is MUL_LATENCY+2 cycles.
//  - mul_x/mul_y hold their value after the response. They change only on a new grant.
//  - A requester dropping req_valid while not granted is legal and loses nothing.
//  - Operands are not sampled outside the handshake cycle.
//  - rsp_ready held high in RESP: completes in one cycle. rsp_ready high outside RESP: ignored.
//  - Reset asserted mid-operation aborts the transaction: the response is dropped and every output
//    returns to its reset value immediately (asynchronously).
//  - Width rule: all arithmetic is unsigned. rsp_result is exactly mul_result; no rounding or compensation.
// CONFIGURATION
//  TRUNC_ERR_STATS_EN defined:
//  - Adds output err_count [15:0] and output max_err [RESULT_BIT_WIDTH-1:0], both reset to 0.
//  - At capture, ideal = (mul_x*mul_y)[2*BIT_WIDTH-1 -: RESULT_BIT_WIDTH], computed internally.
//  - If ideal != mul_result, err_count increments, saturating at 16'hFFFF.
//  - max_err <= max(max_err, ideal - mul_result), with the difference taken as unsigned and
//    clamped to 0 when negative.
//  TRUNC_ERR_STATS_EN not defined: neither port exists and there is no exact-product logic.
// TESTING
//  - Bench pairs the block with a behavioural multiplier model. MUL_LATENCY is 1 and 3.
//  1 Single request: req 0, x=63 y=63 -> rsp_id=0, rsp_result=mul_result (ideal 248),
//    rsp_valid 1+MUL_LATENCY edges after grant.
//  2 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one grant per MUL_LATENCY+2 cycles.
//  3 Backpressure: rsp_ready=0 for 10 cycles in RESP -> outputs stable, no new req_ready,
//    completion on the first rsp_ready=1.
//  4 Sparse requests, only req 2 then only req 1 -> req 2 granted, then rr_ptr=3, then req 1
//    granted (wrap path 3->0->1).
//  5 Reset pulse in WAIT -> rsp_valid=0 and busy=0 at once. After release, the pending
//    requester is re-granted from rr_ptr=0.
//  6 TRUNC_ERR_STATS_EN with a model forcing mul_result = ideal-2 on x=40 y=50 (ideal 125)
//    -> err_count=1, max_err=2; an exact result leaves both unchanged.

Source files
------------

// File: rtl/trunc_mult_arbiter.sv
// trunc_mult_arbiter
// Round-robin front end that shares one combinational truncated array multiplier
// among NUM_REQ requesters. A granted request registers its operands onto
// mul_x/mul_y. After MUL_LATENCY settle cycles, the truncated product is captured
// and returned with the requester index.
// Optional build macro: TRUNC_ERR_STATS_EN adds err_count/max_err, which track how far
// the external truncated multiplier deviates from the exact product MSBs.
module trunc_mult_arbiter #(
    parameter int BIT_WIDTH        = 6,
    parameter int RESULT_BIT_WIDTH = 8,
    parameter int NUM_REQ          = 4,
    parameter int MUL_LATENCY      = 1,
    parameter int ID_W             = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_x,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_y,
    output logic [BIT_WIDTH-1:0]          mul_x,
    output logic [BIT_WIDTH-1:0]          mul_y,
    input  logic [RESULT_BIT_WIDTH-1:0]   mul_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [RESULT_BIT_WIDTH-1:0]   rsp_result,
    output logic                          busy
`ifdef TRUNC_ERR_STATS_EN
    ,
    output logic [15:0]                   err_count,
    output logic [RESULT_BIT_WIDTH-1:0]   max_err
`endif
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    scan_idx;
    logic               grant_found;
    logic               capture;
    logic               complete;

    // Requester index at a given offset from the round-robin pointer, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    // Pointer value after serving requester id: the one just after it, wrapping to 0.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    assign capture   = (state == ST_WAIT) && (cnt == CNT_W'(1));
    assign complete  = (state == ST_RESP) && rsp_ready;
    assign req_ready = grant;
    assign busy      = (state != ST_IDLE);

    // Round-robin pick: first valid requester at or after rr_ptr; only offered while idle.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        if (reset && (state == ST_IDLE)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = rr_index(rr_ptr, k);
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found      = 1'b1;
                    grant_idx        = scan_idx;
                    grant[scan_idx]  = 1'b1;
                end
            end
        end
    end

    // Control: IDLE -> WAIT (settle countdown) -> RESP (hold until consumed) -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        cnt   <= CNT_W'(MUL_LATENCY);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (capture) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (complete) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr(rsp_id);
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand registers load only on a grant; the result register loads only at capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_x      <= '0;
            mul_y      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            if (grant_found) begin
                mul_x  <= req_x[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
                mul_y  <= req_y[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
                rsp_id <= grant_idx;
            end
            if (capture) begin
                rsp_result <= mul_result;
            end
        end
    end

`ifdef TRUNC_ERR_STATS_EN
    logic [2*BIT_WIDTH-1:0]      exact_prod;
    logic [RESULT_BIT_WIDTH-1:0] ideal;
    logic [RESULT_BIT_WIDTH-1:0] err_diff;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Unsigned a - b, clamped to zero when b exceeds a.
    function automatic logic [RESULT_BIT_WIDTH-1:0] clamp_sub(
        input logic [RESULT_BIT_WIDTH-1:0] a,
        input logic [RESULT_BIT_WIDTH-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

    assign exact_prod = {{BIT_WIDTH{1'b0}}, mul_x} * {{BIT_WIDTH{1'b0}}, mul_y};
    assign ideal      = exact_prod[2*BIT_WIDTH-1 -: RESULT_BIT_WIDTH];
    assign err_diff   = clamp_sub(ideal, mul_result);

    // Error statistics, updated at the same edge that captures the multiplier output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
            max_err   <= '0;
        end else if (capture) begin
            if (ideal != mul_result) begin
                err_count <= sat_inc16(err_count);
            end
            if (err_diff > max_err) begin
                max_err <= err_diff;
            end
        end
    end
`else
    // Without error statistics the block only forwards the external multiplier output.
`endif

endmodule

// File: tb/tb_trunc_mult_arbiter.sv
// Bench for trunc_mult_arbiter: two instances (MUL_LATENCY 1 and 3), each paired with
// a behavioural truncated multiplier. Expected responses are pushed to per-instance
// queues and popped by a monitor on every response handshake.
module tb_trunc_mult_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] res;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic [23:0] xs, ys;
    logic [3:0]  rv1, rr1, rv3, rr3, hs1, hs3;
    logic [5:0]  mx1, my1, mx3, my3;
    logic [7:0]  mr1, mr3, sres1, sres3;
    logic        sv1, sr1, sv3, sr3, busy1, busy3;
    logic [1:0]  sid1, sid3;
    logic        hold1, hold3, chk_int1, chk_int3, inject;
`ifdef TRUNC_ERR_STATS_EN
    logic [15:0] err1, err3;
    logic [7:0]  maxe1, maxe3;
`endif

    exp_t q1[$];
    exp_t q3[$];
    int   total = 0;
    int   bad   = 0;
    int   g_cyc1 = 0, g_cyc3 = 0;
    bit   have_g1 = 0, have_g3 = 0;
    logic prev_sv1 = 1'b0, prev_sv3 = 1'b0;

    function automatic logic [7:0] tb_ideal(input logic [5:0] x, input logic [5:0] y);
        logic [11:0] p;
        p = {6'd0, x} * {6'd0, y};
        return p[11:4];
    endfunction

    assign mr1 = tb_ideal(mx1, my1) - ((inject && mx1 == 6'd40 && my1 == 6'd50) ? 8'd2 : 8'd0);
    assign mr3 = tb_ideal(mx3, my3);

    trunc_mult_arbiter #(.MUL_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(rr1), .req_x(xs), .req_y(ys),
        .mul_x(mx1), .mul_y(my1), .mul_result(mr1),
        .rsp_valid(sv1), .rsp_ready(sr1), .rsp_id(sid1), .rsp_result(sres1),
        .busy(busy1)
`ifdef TRUNC_ERR_STATS_EN
        , .err_count(err1), .max_err(maxe1)
`endif
    );

    trunc_mult_arbiter #(.MUL_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_ready(rr3), .req_x(xs), .req_y(ys),
        .mul_x(mx3), .mul_y(my3), .mul_result(mr3),
        .rsp_valid(sv3), .rsp_ready(sr3), .rsp_id(sid3), .rsp_result(sres3),
        .busy(busy3)
`ifdef TRUNC_ERR_STATS_EN
        , .err_count(err3), .max_err(maxe3)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic push1(input logic [1:0] id, input logic [7:0] res);
        q1.push_back('{id: id, res: res});
    endtask

    task automatic push3(input logic [1:0] id, input logic [7:0] res);
        q3.push_back('{id: id, res: res});
    endtask

    // One clock: note handshakes at the falling edge, then retire granted requests.
    task automatic tick();
        @(negedge clk);
        hs1 = rv1 & rr1;
        hs3 = rv3 & rr3;
        @(posedge clk);
        #1;
        if (!hold1) rv1 = rv1 & ~hs1;
        if (!hold3) rv3 = rv3 & ~hs3;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (n < 100 && ((which == 1) ? (q1.size() != 0 || busy1) : (q3.size() != 0 || busy3))) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL drain_l%0d timed out with %0d responses outstanding", which,
                     (which == 1) ? q1.size() : q3.size());
            q1.delete();
            q3.delete();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!chk_int1) have_g1 = 0;
                if (rr1 != 0) check("ready_onehot_l1", {31'd0, $onehot(rr1) && ((rr1 & ~rv1) == 0)}, 32'd1);
                if ((rv1 & rr1) != 0) begin
                    if (chk_int1 && have_g1) check("issue_interval_l1", cyc - g_cyc1, 32'd3);
                    g_cyc1 = cyc;
                    have_g1 = chk_int1;
                end
                if (sv1 && !prev_sv1) check("latency_l1", cyc - g_cyc1, 32'd2);
                if (sv1 && sr1) begin
                    if (q1.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected_l1 actual id=%0d result=%0d required=none", sid1, sres1);
                    end else begin
                        e = q1.pop_front();
                        check("rsp_id_l1", {30'd0, sid1}, {30'd0, e.id});
                        check("rsp_result_l1", {24'd0, sres1}, {24'd0, e.res});
                    end
                end

                if (!chk_int3) have_g3 = 0;
                if (rr3 != 0) check("ready_onehot_l3", {31'd0, $onehot(rr3) && ((rr3 & ~rv3) == 0)}, 32'd1);
                if ((rv3 & rr3) != 0) begin
                    if (chk_int3 && have_g3) check("issue_interval_l3", cyc - g_cyc3, 32'd5);
                    g_cyc3 = cyc;
                    have_g3 = chk_int3;
                end
                if (sv3 && !prev_sv3) check("latency_l3", cyc - g_cyc3, 32'd4);
                if (sv3 && sr3) begin
                    if (q3.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected_l3 actual id=%0d result=%0d required=none", sid3, sres3);
                    end else begin
                        e = q3.pop_front();
                        check("rsp_id_l3", {30'd0, sid3}, {30'd0, e.id});
                        check("rsp_result_l3", {24'd0, sres3}, {24'd0, e.res});
                    end
                end
            end
            prev_sv1 = sv1;
            prev_sv3 = sv3;
        end
    endtask

    initial begin
        int n;
        int g;
        reset = 1'b0;
        rv1 = 4'hF; rv3 = 4'hF;
        sr1 = 1'b0; sr3 = 1'b0;
        hold1 = 1'b0; hold3 = 1'b0;
        chk_int1 = 1'b0; chk_int3 = 1'b0;
        inject = 1'b0;
        hs1 = '0; hs3 = '0;
        // operands, requester 3..0: (33,17)->35 (40,50)->125 (10,20)->12 (63,63)->248
        xs = {6'd33, 6'd40, 6'd10, 6'd63};
        ys = {6'd17, 6'd50, 6'd20, 6'd63};

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog expired at cycle %0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values, with every requester valid
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready_l1", {28'd0, rr1}, 32'd0);
        check("reset_req_ready_l3", {28'd0, rr3}, 32'd0);
        check("reset_rsp_valid", {31'd0, sv1}, 32'd0);
        check("reset_rsp_id", {30'd0, sid1}, 32'd0);
        check("reset_rsp_result", {24'd0, sres1}, 32'd0);
        check("reset_mul_x", {26'd0, mx1}, 32'd0);
        check("reset_mul_y", {26'd0, my1}, 32'd0);
        check("reset_busy", {31'd0, busy1}, 32'd0);
`ifdef TRUNC_ERR_STATS_EN
        check("reset_err_count", {16'd0, err1}, 32'd0);
        check("reset_max_err", {24'd0, maxe1}, 32'd0);
`endif
        rv1 = 4'h0; rv3 = 4'h0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Continuous requests, consumer always ready: order 0,1,2,3,0,1
        sr1 = 1'b1; sr3 = 1'b1;
        push1(2'd0, 8'd248); push1(2'd1, 8'd12); push1(2'd2, 8'd125);
        push1(2'd3, 8'd35);  push1(2'd0, 8'd248); push1(2'd1, 8'd12);
        hold1 = 1'b1; chk_int1 = 1'b1; rv1 = 4'hF;
        n = 0; g = 0;
        while (g < 6 && n < 100) begin
            tick();
            if (hs1 != 0) g++;
            n++;
        end
        check("grant_count_l1", g, 32'd6);
        rv1 = 4'h0; hold1 = 1'b0; chk_int1 = 1'b0;
        drain(1);

        // Single request from requester 0 (pointer at 2, wraps to 0)
        rv1 = 4'b0001;
        push1(2'd0, 8'd248);
        #1;
        check("single_ready_l1", {28'd0, rr1}, 32'd1);
        drain(1);
        check("mul_x_held", {26'd0, mx1}, 32'd63);

        // Backpressure: requester 3 served, consumer stalls 10 cycles, requester 0 waits
        sr1 = 1'b0;
        rv1 = 4'b1000;
        push1(2'd3, 8'd35); push1(2'd0, 8'd248);
        n = 0;
        while (!sv1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_rsp_valid_rise", {31'd0, sv1}, 32'd1);
        rv1 = rv1 | 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rsp_valid", {31'd0, sv1}, 32'd1);
            check("bp_rsp_id", {30'd0, sid1}, 32'd3);
            check("bp_rsp_result", {24'd0, sres1}, 32'd35);
            check("bp_req_ready", {28'd0, rr1}, 32'd0);
        end
        sr1 = 1'b1;
        tick();
        check("bp_complete", {31'd0, sv1}, 32'd0);
        drain(1);

        // Sparse: only requester 2 (pointer 1), then only requester 1 (pointer 3 wraps)
        rv1 = 4'b0100;
        push1(2'd2, 8'd125);
        #1;
        check("sparse_ready_2", {28'd0, rr1}, 32'd4);
        drain(1);
        rv1 = 4'b0010;
        push1(2'd1, 8'd12);
        #1;
        check("sparse_ready_wrap", {28'd0, rr1}, 32'd2);
        drain(1);

        // Reset pulse while waiting on requester 2 (pointer 2); response is dropped
        rv1 = 4'b0100;
        tick();
        check("abort_busy_before", {31'd0, busy1}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, sv1}, 32'd0);
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_rsp_id", {30'd0, sid1}, 32'd0);
        check("abort_mul_x", {26'd0, mx1}, 32'd0);
        rv1 = 4'b0110;
        #1;
        check("abort_req_ready", {28'd0, rr1}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        push1(2'd1, 8'd12); push1(2'd2, 8'd125);
        #1;
        check("regrant_from_zero", {28'd0, rr1}, 32'd2);
        drain(1);

`ifdef TRUNC_ERR_STATS_EN
        // Multiplier returns ideal-2 for 40*50: one error of magnitude 2
        inject = 1'b1;
        rv1 = 4'b0100;
        push1(2'd2, 8'd123);
        drain(1);
        check("stats_err_count", {16'd0, err1}, 32'd1);
        check("stats_max_err", {24'd0, maxe1}, 32'd2);
        inject = 1'b0;
        rv1 = 4'b0001;
        push1(2'd0, 8'd248);
        drain(1);
        check("stats_err_count_exact", {16'd0, err1}, 32'd1);
        check("stats_max_err_exact", {24'd0, maxe1}, 32'd2);
`endif

        // MUL_LATENCY=3: single request, then continuous from pointer 1
        rv3 = 4'b0001;
        push3(2'd0, 8'd248);
        #1;
        check("single_ready_l3", {28'd0, rr3}, 32'd1);
        drain(3);
        push3(2'd1, 8'd12); push3(2'd2, 8'd125); push3(2'd3, 8'd35); push3(2'd0, 8'd248);
        hold3 = 1'b1; chk_int3 = 1'b1; rv3 = 4'hF;
        n = 0; g = 0;
        while (g < 4 && n < 100) begin
            tick();
            if (hs3 != 0) g++;
            n++;
        end
        check("grant_count_l3", g, 32'd4);
        rv3 = 4'h0; hold3 = 1'b0; chk_int3 = 1'b0;
        drain(3);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
